// File: rtl/ftdi_245_imit.sv
// Behavioural model of an FT600/FT601 245-synchronous FIFO bus with host-side streaming ports.
// Define FTDI_LOOPBACK_EN to route drained TX packets straight back into the RX buffer.
module ftdi_245_imit #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int TURN_DLY = 4
) (
    input  logic                iCLK,
    input  logic                iRESET,
    inout  wire  [DATA_W-1:0]   ioDATA,
    inout  wire  [DATA_W/8-1:0] ioBE,
    output logic                oTXE_N,
    output logic                oRXF_N,
    input  logic                iOE_N,
    input  logic                iRD_N,
    input  logic                iWR_N,
    input  logic [DATA_W-1:0]   iPC_DATA,
    input  logic                iPC_VALID,
    input  logic                iPC_LAST,
    output logic                oPC_READY,
    output logic [DATA_W-1:0]   oPC_DATA,
    output logic [DATA_W/8-1:0] oPC_BE,
    output logic                oPC_VALID,
    input  logic                iPC_READY,
    output logic [2:0]          oERR,
    output logic [15:0]         oTX_PKT_CNT,
    output logic [15:0]         oRX_PKT_CNT
);
    localparam int BE_W = DATA_W / 8;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(TURN_DLY + 1);

    typedef enum logic [1:0] {T_WAIT, T_OPEN, T_DRAIN} txState_t;
    typedef enum logic [1:0] {R_FILL, R_WAIT, R_SEND} rxState_t;

    txState_t txState, txNext;
    rxState_t rxState, rxNext;

    logic [DATA_W+BE_W-1:0] txMem [DEPTH];
    logic [DATA_W-1:0]      rxMem [DEPTH];
    logic [AW:0]            txWrPtr, txRdPtr, rxWrPtr, rxRdPtr;
    logic [AW:0]            txWrInc, txRdInc, rxWrInc, rxRdInc;
    logic [CW-1:0]          txCnt, rxCnt;
    logic                   wrPrev, wrRise;
    logic                   txPush, txPop, txFullNext, txLastPop;
    logic                   rxPush, rxPop, rxFullNext, rxLastPop, rxPushLast;
    logic [DATA_W-1:0]      rxPushData;
    logic                   busDrive;
    logic                   txeD, rxfD, validD, readyD;

    assign txWrInc    = txWrPtr + 1'b1;
    assign txRdInc    = txRdPtr + 1'b1;
    assign rxWrInc    = rxWrPtr + 1'b1;
    assign rxRdInc    = rxRdPtr + 1'b1;
    assign txFullNext = (txWrInc[AW] != txRdPtr[AW]) && (txWrInc[AW-1:0] == txRdPtr[AW-1:0]);
    assign rxFullNext = (rxWrInc[AW] != rxRdPtr[AW]) && (rxWrInc[AW-1:0] == rxRdPtr[AW-1:0]);
    assign txLastPop  = (txRdInc == txWrPtr);
    assign rxLastPop  = (rxRdInc == rxWrPtr);
    assign wrRise     = iWR_N && !wrPrev;

    // A write is only legal while the bus is not turned around towards the FPGA.
    assign txPush = (txState == T_OPEN) && !iWR_N && iOE_N && iRD_N && (ioBE != '0);
    assign rxPop  = (rxState == R_SEND) && !iOE_N && !iRD_N && iWR_N;

    assign {oPC_DATA, oPC_BE} = txMem[txRdPtr[AW-1:0]];

`ifdef FTDI_LOOPBACK_EN
    logic unusedHost;
    assign unusedHost = ^{iPC_DATA, iPC_VALID, iPC_LAST, iPC_READY};
    assign txPop      = (txState == T_DRAIN) && (rxState == R_FILL);
    assign rxPush     = txPop;
    assign rxPushData = oPC_DATA;
    assign rxPushLast = txLastPop;
`else
    assign txPop      = (txState == T_DRAIN) && oPC_VALID && iPC_READY;
    assign rxPush     = (rxState == R_FILL) && oPC_READY && iPC_VALID;
    assign rxPushData = iPC_DATA;
    assign rxPushLast = iPC_LAST;
`endif

    // RX head is presented on the bus only while the FPGA has turned it around and is not writing.
    assign busDrive = iRESET && !iOE_N && iWR_N;
    assign ioDATA   = busDrive ? rxMem[rxRdPtr[AW-1:0]] : {DATA_W{1'bz}};
    assign ioBE     = busDrive ? {BE_W{1'b1}} : {BE_W{1'bz}};

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            txState   <= T_WAIT;
            rxState   <= R_FILL;
            oTXE_N    <= 1'b1;
            oRXF_N    <= 1'b1;
            oPC_VALID <= 1'b0;
            oPC_READY <= 1'b0;
        end else begin
            txState   <= txNext;
            rxState   <= rxNext;
            oTXE_N    <= txeD;
            oRXF_N    <= rxfD;
            oPC_VALID <= validD;
            oPC_READY <= readyD;
        end
    end

    always_comb begin
        txNext = txState;
        rxNext = rxState;
        unique case (txState)
            T_WAIT:  if (txCnt == CW'(TURN_DLY - 1)) txNext = T_OPEN;
            T_OPEN:  if ((txPush && txFullNext) || (wrRise && (txWrPtr != txRdPtr))) txNext = T_DRAIN;
            T_DRAIN: if (txPop && txLastPop) txNext = T_WAIT;
            default: txNext = T_WAIT;
        endcase
        unique case (rxState)
            R_FILL:  if (rxPush && (rxFullNext || rxPushLast)) rxNext = R_WAIT;
            R_WAIT:  if (rxCnt == CW'(TURN_DLY - 1)) rxNext = R_SEND;
            R_SEND:  if (rxPop && rxLastPop) rxNext = R_FILL;
            default: rxNext = R_FILL;
        endcase
    end

    // Flags are decoded from the next state so the registered copy always matches the live state.
    always_comb begin
        txeD = (txNext != T_OPEN);
        rxfD = (rxNext != R_SEND);
`ifdef FTDI_LOOPBACK_EN
        validD = 1'b0;
        readyD = 1'b0;
`else
        validD = (txNext == T_DRAIN);
        readyD = (rxNext == R_FILL);
`endif
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            txWrPtr     <= '0;
            txRdPtr     <= '0;
            rxWrPtr     <= '0;
            rxRdPtr     <= '0;
            txCnt       <= '0;
            rxCnt       <= '0;
            wrPrev      <= 1'b1;
            oERR        <= '0;
            oTX_PKT_CNT <= '0;
            oRX_PKT_CNT <= '0;
        end else begin
            wrPrev <= iWR_N;
            if (txPush) txWrPtr <= txWrInc;
            if (txPop)  txRdPtr <= txRdInc;
            if (rxPush) rxWrPtr <= rxWrInc;
            if (rxPop)  rxRdPtr <= rxRdInc;
            txCnt <= ((txState == T_WAIT) && (txNext == T_WAIT)) ? txCnt + 1'b1 : '0;
            rxCnt <= ((rxState == R_WAIT) && (rxNext == R_WAIT)) ? rxCnt + 1'b1 : '0;
            if ((txState == T_OPEN) && (txNext == T_DRAIN)) oTX_PKT_CNT <= oTX_PKT_CNT + 1'b1;
            if (rxPop && rxLastPop) oRX_PKT_CNT <= oRX_PKT_CNT + 1'b1;
            oERR <= oERR | {!iRD_N && oRXF_N, !iWR_N && oTXE_N, !iWR_N && (!iOE_N || !iRD_N)};
        end
    end

    always_ff @(posedge iCLK) begin
        if (txPush) txMem[txWrPtr[AW-1:0]] <= {ioDATA, ioBE};
        if (rxPush) rxMem[rxWrPtr[AW-1:0]] <= rxPushData;
    end
endmodule

// File: doc/ftdi_245_imit.md
FTDI_245_IMIT -- requirements
Module: ftdi_245_imit

Interface
REQ-001 SHALL have parameters:
- DATA_W, 32, bus width; 16 (FT600) or 32 (FT601)
- DEPTH, 256, words per packet buffer; power of two, 4..1024
- TURN_DLY, 4, clocks between packet end and flag re-assertion
REQ-002 SHALL have ports (clock and reset first):
- iCLK  in  1  bus clock; the only clock
- iRESET  in  1  asynchronous, active-low reset
- ioDATA  inout  DATA_W  FIFO data bus
- ioBE  inout  DATA_W/8  byte enables
- oTXE_N  out  1  low: model accepts FPGA writes
- oRXF_N  out  1  low: model holds data for FPGA reads
- iOE_N  in  1  bus turnaround, FPGA read
- iRD_N  in  1  read strobe
- iWR_N  in  1  write strobe
- iPC_DATA  in  DATA_W  host-side data into RX buffer
- iPC_VALID  in  1  host word valid
- iPC_LAST  in  1  host word closes packet
- oPC_READY  out  1  RX buffer accepts host word
- oPC_DATA  out  DATA_W  TX buffer head to host
- oPC_BE  out  DATA_W/8  byte enables of oPC_DATA
- oPC_VALID  out  1  TX head valid
- iPC_READY  in  1  host pops TX head
- oERR  out  3  sticky errors: [0] WR_N with OE_N/RD_N low, [1] write while oTXE_N high, [2] RD_N low while oRXF_N high
- oTX_PKT_CNT  out  16  FPGA->host packets closed, wraps
- oRX_PKT_CNT  out  16  host->FPGA packets delivered, wraps

Function
REQ-003 All outputs SHALL be registered except ioDATA/ioBE drive and oPC_DATA/oPC_BE (buffer head).
REQ-004 TX path FSM SHALL have states T_WAIT, T_OPEN, T_DRAIN; T_WAIT counts TURN_DLY clocks then T_OPEN with oTXE_N=0.
REQ-005 In T_OPEN each edge with iWR_N=0 and ioBE!=0 SHALL store {ioDATA,ioBE}; ioBE=0 words are discarded, not counted.
REQ-006 T_OPEN SHALL go to T_DRAIN, oTXE_N=1 on next clock, when DEPTH-th word stored or iWR_N rises with >=1 word stored; oTX_PKT_CNT increments then.
REQ-007 iWR_N rising with 0 words stored SHALL leave state unchanged.
REQ-008 T_DRAIN SHALL pop one word per clock with oPC_VALID&iPC_READY; on last pop go to T_WAIT.
REQ-009 RX path FSM SHALL have states R_FILL, R_WAIT, R_SEND; R_FILL: oPC_READY=1, push on iPC_VALID.
REQ-010 R_FILL SHALL go to R_WAIT when DEPTH-th word or a word with iPC_LAST is pushed; R_WAIT counts TURN_DLY then R_SEND, oRXF_N=0.
REQ-011 ioDATA/ioBE SHALL be driven with RX head ({word, all-ones BE}) only while iOE_N=0 and iWR_N=1, else high-Z.
REQ-012 In R_SEND each edge with iOE_N=0 and iRD_N=0 SHALL pop one word; popping last word SHALL set oRXF_N=1 next clock, increment oRX_PKT_CNT, return to R_FILL.
REQ-013 iRD_N=0 with iOE_N=1 SHALL not pop.
REQ-014 oERR bits SHALL set on the offending edge and hold until reset; erroneous writes/reads have no buffer effect.
REQ-015 TX and RX FSMs SHALL run independently; simultaneous host push and FPGA write SHALL both complete.
REQ-016 Buffer pointers SHALL be log2(DEPTH)+1 bits; full/empty from MSB compare.

Reset
REQ-017 iRESET=0 SHALL asynchronously force: oTXE_N=1, oRXF_N=1, oPC_READY=0, oPC_VALID=0, oERR=0, both counters 0, buffers empty, TX in T_WAIT (count 0), RX in R_FILL, bus high-Z.
REQ-018 Reset mid-packet SHALL discard buffered words; oTXE_N falls TURN_DLY clocks after release.

Configuration
REQ-019 Macro FTDI_LOOPBACK_EN defined: TX drain SHALL feed RX fill internally (last TX word acts as iPC_LAST), iPC_* ignored, oPC_VALID=0, oPC_READY=0.
REQ-020 Macro undefined: host ports operate per REQ-008..010; no internal path.

Verification
REQ-021 Release reset, DEPTH=256, TURN_DLY=4 -> oTXE_N falls 4 clocks later; 256 writes -> oTXE_N=1, oTX_PKT_CNT=1, host reads 256 identical words.
REQ-022 Write 10 words, raise iWR_N -> oTXE_N=1 next clock, host sees 10 words, oTXE_N low again 4 clocks after drain.
REQ-023 Host pushes 3 words, last with iPC_LAST -> oRXF_N=0 after 4 clocks; OE/RD read returns same 3 words, BE=all ones; oRXF_N=1, oRX_PKT_CNT=1.
REQ-024 iWR_N=0 while iOE_N=0 -> oERR[0]=1 and stays after bus idle; iRD_N=0 while oRXF_N=1 -> oERR[2]=1.
REQ-025 FTDI_LOOPBACK_EN, DATA_W=16: write 5 words 16'h1234.. -> oRXF_N falls, read returns same 5 words in order.
REQ-026 Assert iRESET after 100 of 256 writes -> all flags high, counters 0; post-reset packet unaffected.
